dca_matrix_row_drainer: RTL

- Downstream consumer stage for the DCA matrix register. It empties a loaded N x N matrix register one row per transfer.
- Each row is read from the register's upmost row and pushed onto a valid/ready row stream. The block drives the register's shift_up, and its transpose for column-order draining.
- It sits between the matrix register and the DCA result/write-back path, and converts a "matrix ready" event into a backpressure-aware row stream.

---
 rtl/dca_matrix_row_drainer_pkg.sv | 23 ++
 rtl/dca_row_out_reg.sv | 37 +++
 rtl/dca_matrix_row_drainer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dca_matrix_row_drainer_pkg.sv
// dca_matrix_row_drainer_pkg: shared dimension helpers and the drain FSM state type
// used by the DCA matrix row drainer and its row holding register.
package dca_matrix_row_drainer_pkg;

  typedef enum logic [2:0] {
    DRAIN_IDLE,
    DRAIN_XPOSE,
    DRAIN_LOAD,
    DRAIN_SEND,
    DRAIN_FIN
  } drain_state_e;

  // Width of one matrix row: N elements of bw bits each.
  function automatic int unsigned row_width(input int unsigned n, input int unsigned bw);
    return n * bw;
  endfunction

  // Row counter width; must hold the value N itself, not just N-1.
  function automatic int unsigned row_index_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dca_row_out_reg.sv
// dca_row_out_reg: valid/ready holding register for one row payload plus its
// index and last flag. Loads on a strobe and holds everything under backpressure.
module dca_row_out_reg #(
  parameter int unsigned BW_DATA  = 256,
  parameter int unsigned BW_INDEX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [BW_DATA-1:0]  load_data,
  input  logic [BW_INDEX-1:0] load_index,
  input  logic                load_last,
  input  logic                ready,
  output logic                valid,
  output logic [BW_DATA-1:0]  data,
  output logic [BW_INDEX-1:0] index,
  output logic                last
);

  // A load wins over a handshake so back-to-back rows keep valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      index <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      index <= load_index;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dca_matrix_row_drainer.sv
// dca_matrix_row_drainer: empties an N x N matrix register one row per transfer
// onto a valid/ready row stream, optionally transposing it first.
// Optional feature macro: DCA_MATRIX_ROW_DRAINER_PARTIAL_EN (adds drain_num_rows).
module dca_matrix_row_drainer
  import dca_matrix_row_drainer_pkg::*;
#(
  parameter  int unsigned MATRIX_SIZE_PARA = 8,
  parameter  int unsigned BW_TENSOR_SCALAR = 32,
  localparam int unsigned BW_TENSOR_ROW    = row_width(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR),
  localparam int unsigned BW_ROW_INDEX     = row_index_width(MATRIX_SIZE_PARA)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     start_transpose,
  output logic                     busy,
  output logic                     done,
  output logic                     mreg_shift_up,
  output logic                     mreg_transpose,
  input  logic [BW_TENSOR_ROW-1:0] mreg_upmost_rdata,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [BW_TENSOR_ROW-1:0] row_data,
  output logic [BW_ROW_INDEX-1:0]  row_index,
  output logic                     row_last
`ifdef DCA_MATRIX_ROW_DRAINER_PARTIAL_EN
  ,
  input  logic [BW_ROW_INDEX-1:0]  drain_num_rows
`endif
);

  localparam logic [BW_ROW_INDEX-1:0] ROWS_FULL = BW_ROW_INDEX'(MATRIX_SIZE_PARA);
  localparam logic [BW_ROW_INDEX-1:0] ROW_ONE   = BW_ROW_INDEX'(1);

  drain_state_e                state, state_next;
  logic [BW_ROW_INDEX-1:0]     cnt;
  logic [BW_ROW_INDEX-1:0]     num_rows;
  logic [BW_ROW_INDEX-1:0]     start_rows;
  logic                        load;
  logic                        load_last;

`ifdef DCA_MATRIX_ROW_DRAINER_PARTIAL_EN
  assign start_rows = (drain_num_rows > ROWS_FULL) ? ROWS_FULL : drain_num_rows;

  // Row count for this drain, captured together with start.
  always_ff @(posedge clk) begin
    if (rst)
      num_rows <= '0;
    else if (state == DRAIN_IDLE && start)
      num_rows <= start_rows;
  end
`else
  assign start_rows = ROWS_FULL;
  assign num_rows   = ROWS_FULL;
`endif

  assign load_last = (cnt == num_rows - ROW_ONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= DRAIN_IDLE;
    else
      state <= state_next;
  end

  // Row counter: cleared on an accepted start, advanced on every row load.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state == DRAIN_IDLE && start)
      cnt <= '0;
    else if (load)
      cnt <= cnt + ROW_ONE;
  end

  // Next state and strobes; all strobes are held low while rst is asserted so
  // a mid-drain reset does not disturb the matrix register any further.
  always_comb begin
    state_next     = state;
    load           = 1'b0;
    mreg_shift_up  = 1'b0;
    mreg_transpose = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    if (!rst) begin
      busy = (state != DRAIN_IDLE);
      unique case (state)
        DRAIN_IDLE: begin
          if (start) begin
            if (start_transpose)
              state_next = DRAIN_XPOSE;
            else if (start_rows == '0)
              state_next = DRAIN_FIN;
            else
              state_next = DRAIN_LOAD;
          end
        end
        DRAIN_XPOSE: begin
          mreg_transpose = 1'b1;
          state_next     = (num_rows == '0) ? DRAIN_FIN : DRAIN_LOAD;
        end
        DRAIN_LOAD: begin
          load          = 1'b1;
          mreg_shift_up = 1'b1;
          state_next    = DRAIN_SEND;
        end
        DRAIN_SEND: begin
          if (row_ready) begin
            if (cnt < num_rows) begin
              load          = 1'b1;
              mreg_shift_up = 1'b1;
            end else begin
              state_next = DRAIN_FIN;
            end
          end
        end
        DRAIN_FIN: begin
          done       = 1'b1;
          state_next = DRAIN_IDLE;
        end
        default: state_next = DRAIN_IDLE;
      endcase
    end
  end

  dca_row_out_reg #(
    .BW_DATA  (BW_TENSOR_ROW),
    .BW_INDEX (BW_ROW_INDEX)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (mreg_upmost_rdata),
    .load_index (cnt),
    .load_last  (load_last),
    .ready      (row_ready),
    .valid      (row_valid),
    .data       (row_data),
    .index      (row_index),
    .last       (row_last)
  );

endmodule
